// File: rtl/sprite_rom_sched_if.sv
// Bundle of the renderer, host and sprite-ROM signals around sprite_rom_sched.
// The scheduler connects through the slave modport and its environment through the master modport.
interface sprite_rom_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int COL_W  = 4
);
  localparam int ROW_W = ADDR_W - COL_W;

  // renderer row request and pixel stream
  logic              row_req;
  logic [ROW_W-1:0]  row_idx;
  logic              row_ack;
  logic              px_valid;
  logic              px_ready;
  logic [DATA_W-1:0] px_data;
  logic [COL_W-1:0]  px_col;
  logic              row_done;

  // host debug read port
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  // sprite ROM side
  logic [ADDR_W-1:0] rom_address;
  logic              rom_clken;
  logic [DATA_W-1:0] rom_readdata;

  modport slave (
    input  row_req, row_idx, px_ready, host_req, host_addr, rom_readdata,
    output row_ack, px_valid, px_data, px_col, row_done,
    output host_ack, host_rvalid, host_rdata, rom_address, rom_clken
  );

  modport master (
    output row_req, row_idx, px_ready, host_req, host_addr, rom_readdata,
    input  row_ack, px_valid, px_data, px_col, row_done,
    input  host_ack, host_rvalid, host_rdata, rom_address, rom_clken
  );
endinterface

// File: rtl/sprite_rom_sched.sv
// Shares one single-port sprite ROM between a renderer fetching 16-pixel row bursts
// with backpressure and a host port doing single-word debug reads.
module sprite_rom_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int COL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  sprite_rom_sched_if.slave bus
);
  localparam logic [COL_W-1:0] LAST_COL = '1;

  typedef enum logic [1:0] {IDLE, BURST, HOST} state_t;

  state_t            state_reg, state_next;
  logic              host_owed_reg;
  logic              host_phase_reg;

  // Burst pipeline: issue (address on ROM port) -> rom (ROM q valid) -> px (capture)
  logic [ADDR_W-1:0] rom_addr_reg;
  logic              issue_valid_reg;
  logic              rom_valid_reg;
  logic [COL_W-1:0]  rom_col_reg;
  logic              px_valid_reg;
  logic [COL_W-1:0]  px_col_reg;
  logic [DATA_W-1:0] px_data_reg;

  logic              row_ack_reg;
  logic              host_ack_reg;
  logic              host_rvalid_reg;
  logic [DATA_W-1:0] host_rdata_reg;

  logic              grant_row;
  logic              grant_host;
  logic              pipe_en;
  logic              burst_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_row) begin
          state_next = BURST;
        end else if (grant_host) begin
          state_next = HOST;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_next = IDLE;
        end
      end
      HOST: begin
        if (host_phase_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A stalled pixel freezes the whole burst pipeline, ROM included, via one global enable.
  always_comb begin
    grant_row  = 1'b0;
    grant_host = 1'b0;
    pipe_en    = 1'b1;
    burst_end  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.row_req && !(bus.host_req && host_owed_reg)) begin
          grant_row = 1'b1;
        end else if (bus.host_req) begin
          grant_host = 1'b1;
        end
      end
      BURST: begin
        pipe_en   = !px_valid_reg || bus.px_ready;
        burst_end = px_valid_reg && bus.px_ready && (px_col_reg == LAST_COL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_owed_reg   <= 1'b0;
      host_phase_reg  <= 1'b0;
      rom_addr_reg    <= '0;
      issue_valid_reg <= 1'b0;
      rom_valid_reg   <= 1'b0;
      rom_col_reg     <= '0;
      px_valid_reg    <= 1'b0;
      px_col_reg      <= '0;
      px_data_reg     <= '0;
      row_ack_reg     <= 1'b0;
      host_ack_reg    <= 1'b0;
      host_rvalid_reg <= 1'b0;
      host_rdata_reg  <= '0;
    end else begin
      row_ack_reg     <= grant_row;
      host_ack_reg    <= grant_host;
      host_rvalid_reg <= 1'b0;

      // The renderer is only granted over a waiting host when host_owed is clear,
      // so owing reduces to whether the host was waiting at that grant.
      if (grant_row) begin
        host_owed_reg <= bus.host_req;
      end else if (grant_host) begin
        host_owed_reg <= 1'b0;
      end

      if (grant_row) begin
        rom_addr_reg    <= {bus.row_idx, {COL_W{1'b0}}};
        issue_valid_reg <= 1'b1;
        rom_valid_reg   <= 1'b0;
        px_valid_reg    <= 1'b0;
      end else if (grant_host) begin
        rom_addr_reg   <= bus.host_addr;
        host_phase_reg <= 1'b0;
      end else if (state_reg == BURST && pipe_en) begin
        // Column wraps never reach the row bits: issuing stops at the last column.
        if (issue_valid_reg && rom_addr_reg[COL_W-1:0] != LAST_COL) begin
          rom_addr_reg <= {rom_addr_reg[ADDR_W-1:COL_W], rom_addr_reg[COL_W-1:0] + COL_W'(1)};
        end else begin
          issue_valid_reg <= 1'b0;
        end
        rom_valid_reg <= issue_valid_reg;
        rom_col_reg   <= rom_addr_reg[COL_W-1:0];
        px_valid_reg  <= rom_valid_reg;
        if (rom_valid_reg) begin
          px_col_reg  <= rom_col_reg;
          px_data_reg <= bus.rom_readdata;
        end
      end else if (state_reg == HOST) begin
        host_phase_reg <= 1'b1;
        if (host_phase_reg) begin
          host_rdata_reg  <= bus.rom_readdata;
          host_rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.row_ack     = row_ack_reg;
  assign bus.px_valid    = px_valid_reg;
  assign bus.px_data     = px_data_reg;
  assign bus.px_col      = px_col_reg;
  assign bus.row_done    = px_valid_reg && (px_col_reg == LAST_COL);
  assign bus.host_ack    = host_ack_reg;
  assign bus.host_rvalid = host_rvalid_reg;
  assign bus.host_rdata  = host_rdata_reg;
  assign bus.rom_address = rom_addr_reg;
  assign bus.rom_clken   = pipe_en;
endmodule

// File: tb/tb_sprite_rom_sched.sv
// Directed bench for sprite_rom_sched: a sprite ROM model with word(a) = {a, ~a},
// a pixel/host-read expectation model, and literal checks of the key timings.
module tb_sprite_rom_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_rom_sched_if bus();
  sprite_rom_sched dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {a, ~a};
  endfunction

  // ROM: address registered on enabled edges, q combinational from it
  logic [7:0] rom_addr_q = '0;
  always @(posedge clk) if (bus.rom_clken) rom_addr_q <= bus.rom_address;
  assign bus.rom_readdata = rom_word(rom_addr_q);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct packed { logic [15:0] data; logic [3:0] col; } px_t;
  px_t        exp_q[$];
  logic [3:0] idx_at_edge;
  logic [7:0] addr_at_edge;
  int         host_due = -1;
  logic [15:0] host_exp;
  logic        stall_prev = 1'b0;
  logic [15:0] data_prev;
  logic [3:0]  col_prev;
  int          px_count = 0;
  int          done_count = 0;

  // request fields as seen by the granting edge
  always @(posedge clk) begin
    idx_at_edge  <= bus.row_idx;
    addr_at_edge <= bus.host_addr;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      host_due   = -1;
      stall_prev = 1'b0;
    end else begin
      px_t e;
      chk("clken_rule", 32'(bus.rom_clken), 32'(!(bus.px_valid && !bus.px_ready)));
      chk("ack_exclusive", 32'(bus.row_ack && bus.host_ack), 32'd0);
      chk("row_done_col", 32'(bus.row_done), 32'(bus.px_valid && bus.px_col == 4'hF));
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.px_valid), 32'd1);
        chk("stall_data", 32'(bus.px_data), 32'(data_prev));
        chk("stall_col", 32'(bus.px_col), 32'(col_prev));
      end
      if (bus.px_valid && bus.px_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL px_unexpected: got col %0d data %0h expected no pixel at %0t",
                   bus.px_col, bus.px_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("px_data", 32'(bus.px_data), 32'(e.data));
          chk("px_col", 32'(bus.px_col), 32'(e.col));
          px_count++;
          if (bus.row_done) done_count++;
        end
      end
      stall_prev = bus.px_valid && !bus.px_ready;
      data_prev  = bus.px_data;
      col_prev   = bus.px_col;

      if (host_due > 0) host_due--;
      if (host_due == 0) begin
        chk("host_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("host_rdata", 32'(bus.host_rdata), 32'(host_exp));
        host_due = -1;
      end else begin
        chk("host_rvalid_idle", 32'(bus.host_rvalid), 32'd0);
      end

      if (bus.row_ack) begin
        for (int c = 0; c < 16; c++) begin
          e.col  = 4'(c);
          e.data = rom_word({idx_at_edge, 4'(c)});
          exp_q.push_back(e);
        end
      end
      if (bus.host_ack) begin
        host_due = 2;
        host_exp = rom_word(addr_at_edge);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name, output int n, output logic got_row, output logic got_host);
    n = 0;
    while (!(bus.row_ack || bus.host_ack) && n < 200) begin
      tick();
      n++;
    end
    if (!(bus.row_ack || bus.host_ack)) begin
      checks++;
      errors++;
      $display("FAIL %s: got no ack expected ack within 200 cycles", name);
    end
    got_row  = bus.row_ack;
    got_host = bus.host_ack;
  endtask

  task automatic wait_px_col(input string name, input logic [3:0] col);
    int n = 0;
    while (!(bus.px_valid && bus.px_col == col) && n < 200) begin
      tick();
      n++;
    end
    if (!(bus.px_valid && bus.px_col == col)) begin
      checks++;
      errors++;
      $display("FAIL %s: got no pixel expected col %0d within 200 cycles", name, col);
    end
  endtask

  task automatic wait_burst_end(input string name);
    int n = 0;
    while (!(bus.px_valid && bus.px_ready && bus.row_done) && n < 200) begin
      tick();
      n++;
    end
    if (!(bus.px_valid && bus.px_ready && bus.row_done)) begin
      checks++;
      errors++;
      $display("FAIL %s: got no row_done expected burst end within 200 cycles", name);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int   n;
    int   d0;
    logic gr, gh;
    bus.row_req   = 1'b0;
    bus.row_idx   = '0;
    bus.px_ready  = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_addr = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_px_valid", 32'(bus.px_valid), 32'd0);
    chk("rst_row_ack", 32'(bus.row_ack), 32'd0);
    chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_rom_address", 32'(bus.rom_address), 32'd0);
    chk("rst_rom_clken", 32'(bus.rom_clken), 32'd1);
    chk("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
    rst = 1'b0;
    tick();

    // row 3, no backpressure
    bus.row_idx = 4'd3;
    bus.row_req = 1'b1;
    wait_ack("t1_ack", n, gr, gh);
    bus.row_req = 1'b0;
    chk("t1_ack_latency", 32'(n), 32'd1);
    chk("t1_ack_is_row", 32'(gr), 32'd1);
    chk("t1_addr", 32'(bus.rom_address), 32'd48);
    tick();
    chk("t1_valid_e1", 32'(bus.px_valid), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(bus.px_valid), 32'd1);
    chk("t1_first_data", 32'(bus.px_data), 32'h30CF);
    chk("t1_first_col", 32'(bus.px_col), 32'd0);
    wait_burst_end("t1_end");
    chk("t1_px_count", 32'(px_count), 32'd16);
    chk("t1_done_count", 32'(done_count), 32'd1);
    $display("t1 row 3 burst: %0d pixels, %0d row_done", px_count, done_count);

    // row 0 with a 5-cycle stall on column 7
    bus.row_idx = 4'd0;
    bus.row_req = 1'b1;
    wait_ack("t2_ack", n, gr, gh);
    bus.row_req = 1'b0;
    wait_px_col("t2_col7", 4'd7);
    bus.px_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_col", 32'(bus.px_col), 32'd7);
      chk("t2_hold_data", 32'(bus.px_data), 32'h07F8);
      chk("t2_clken_low", 32'(bus.rom_clken), 32'd0);
    end
    bus.px_ready = 1'b1;
    wait_burst_end("t2_end");
    chk("t2_px_count", 32'(px_count), 32'd32);
    $display("t2 row 0 stalled burst: %0d pixels total", px_count);

    // single host read
    bus.host_addr = 8'hA5;
    bus.host_req  = 1'b1;
    wait_ack("t3_ack", n, gr, gh);
    bus.host_req  = 1'b0;
    chk("t3_ack_latency", 32'(n), 32'd1);
    chk("t3_ack_is_host", 32'(gh), 32'd1);
    tick();
    chk("t3_rvalid_early", 32'(bus.host_rvalid), 32'd0);
    tick();
    chk("t3_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("t3_rdata", 32'(bus.host_rdata), 32'hA55A);
    tick();
    chk("t3_rvalid_pulse", 32'(bus.host_rvalid), 32'd0);
    chk("t3_rdata_hold", 32'(bus.host_rdata), 32'hA55A);
    $display("t3 host read 0xA5: rdata %h", bus.host_rdata);

    // simultaneous requests: renderer, then owed host, then renderer again
    bus.row_idx   = 4'd2;
    bus.host_addr = 8'h10;
    bus.row_req   = 1'b1;
    bus.host_req  = 1'b1;
    wait_ack("t4_ack1", n, gr, gh);
    chk("t4_first_row", 32'(gr), 32'd1);
    chk("t4_first_not_host", 32'(gh), 32'd0);
    tick();
    wait_ack("t4_ack2", n, gr, gh);
    bus.host_req = 1'b0;
    chk("t4_host_after_burst", 32'(n + 1), 32'd19);
    chk("t4_second_host", 32'(gh), 32'd1);
    chk("t4_second_not_row", 32'(gr), 32'd0);
    tick();
    wait_ack("t4_ack3", n, gr, gh);
    bus.row_req = 1'b0;
    chk("t4_row_after_host", 32'(n + 1), 32'd3);
    chk("t4_third_row", 32'(gr), 32'd1);
    wait_burst_end("t4_end");
    chk("t4_px_count", 32'(px_count), 32'd64);
    $display("t4 arbitration: host granted between bursts, %0d pixels total", px_count);

    // reset in the middle of a burst
    bus.row_idx = 4'd5;
    bus.row_req = 1'b1;
    wait_ack("t5_ack", n, gr, gh);
    bus.row_req = 1'b0;
    wait_px_col("t5_col9", 4'd9);
    d0 = done_count;
    #1 rst = 1'b1;
    #1;
    chk("t5_px_valid", 32'(bus.px_valid), 32'd0);
    chk("t5_px_col", 32'(bus.px_col), 32'd0);
    chk("t5_px_data", 32'(bus.px_data), 32'd0);
    chk("t5_row_done", 32'(bus.row_done), 32'd0);
    chk("t5_rom_address", 32'(bus.rom_address), 32'd0);
    chk("t5_rom_clken", 32'(bus.rom_clken), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.row_idx = 4'd15;
    bus.row_req = 1'b1;
    wait_ack("t5_ack15", n, gr, gh);
    bus.row_req = 1'b0;
    tick();
    tick();
    chk("t5_first_valid", 32'(bus.px_valid), 32'd1);
    chk("t5_first_data", 32'(bus.px_data), 32'hF00F);
    wait_burst_end("t5_end");
    chk("t5_done_count", 32'(done_count), 32'(d0 + 1));
    $display("t5 reset mid-burst then row 15: row_done count %0d", done_count);

    // back-to-back host reads
    bus.host_addr = 8'h00;
    bus.host_req  = 1'b1;
    wait_ack("t6_ack1", n, gr, gh);
    chk("t6_ack1_host", 32'(gh), 32'd1);
    bus.host_addr = 8'hFF;
    tick();
    chk("t6_rvalid_a_early", 32'(bus.host_rvalid), 32'd0);
    tick();
    chk("t6_rvalid_a", 32'(bus.host_rvalid), 32'd1);
    chk("t6_rdata_a", 32'(bus.host_rdata), 32'h00FF);
    chk("t6_no_early_ack", 32'(bus.host_ack), 32'd0);
    tick();
    chk("t6_ack2", 32'(bus.host_ack), 32'd1);
    chk("t6_rvalid_gap", 32'(bus.host_rvalid), 32'd0);
    bus.host_req = 1'b0;
    tick();
    chk("t6_rvalid_b_early", 32'(bus.host_rvalid), 32'd0);
    tick();
    chk("t6_rvalid_b", 32'(bus.host_rvalid), 32'd1);
    chk("t6_rdata_b", 32'(bus.host_rdata), 32'hFF00);
    tick();
    $display("t6 back-to-back host reads: last rdata %h", bus.host_rdata);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_rom_sched.md
Name: sprite_rom_sched

Overview:
- Read scheduler for one 256x16 single-port sprite ROM (16x16 pixels, 16-bit colour, one row = 16 consecutive words).
- Shares the ROM between two requesters:
  - a renderer that fetches whole 16-pixel rows as a stream with backpressure;
  - a host port that does single-word debug reads.
- Sits between the sprite ROM instance and the line-buffer fill logic. Drives the ROM address and clock-enable; never writes the ROM.

Parameters:
- ADDR_W, 8, ROM address width (256 words)
- DATA_W, 16, ROM word / pixel width
- COL_W, 4, column index width; row length = 2**COL_W = 16; row index width = ADDR_W-COL_W = 4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- row_req  in  1  renderer row request, level, held until row_ack
- row_idx  in  4  sprite row to fetch, sampled at grant
- row_ack  out  1  one-cycle pulse on renderer grant
- px_valid  out  1  pixel output valid
- px_ready  in  1  downstream ready; transfer when px_valid&px_ready
- px_data  out  16  pixel word
- px_col  out  4  column of px_data
- row_done  out  1  high together with the column-15 pixel
- host_req  in  1  host read request, level, held until host_ack
- host_addr  in  8  host word address, sampled at grant
- host_ack  out  1  one-cycle pulse on host grant
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- host_rdata  out  16  host read data
- rom_address  out  8  registered ROM address
- rom_clken  out  1  ROM clock enable
- rom_readdata  in  16  ROM q

Behaviour:
- Reset (async): state IDLE; all outputs and internal registers 0, except rom_clken=1. An in-flight burst or host read is abandoned: no row_done, no host_rvalid.
- ROM timing: the ROM registers the address at an edge and q is valid after that edge, unregistered. Read latency from driving rom_address to capture is therefore 2 edges.
- States are IDLE, BURST and HOST.
- IDLE arbitration, at most one grant per cycle:
  - row_req only: grant renderer.
  - host_req only: grant host.
  - Both: renderer wins unless host_owed=1.
  - host_owed is set when the renderer is granted while host_req=1, and cleared on host grant. Host therefore waits at most one burst.
- Renderer grant edge E0:
  - row_ack pulses; rom_address<=row_idx*16; col counter<=0; state BURST.
  - Each enabled edge then issues the next address until column 15 is issued.
  - Pixels are captured with column tag; first px_valid rises after edge E2.
- Backpressure (BURST only): rom_clken=px_ready whenever px_valid=1; otherwise rom_clken=1.
  - While rom_clken=0, the address counter, ROM, capture register, px_valid, px_col and px_data all hold. A stalled pixel is held stable.
  - This is a single global pipeline enable, so no skid buffer is needed.
- End of burst: the column-15 pixel is presented with row_done=1.
  - On its transfer, px_valid drops and the state returns to IDLE.
  - Arbitration resumes the next cycle.
  - With px_ready=1 throughout, a burst is 18 cycles from grant to IDLE.
- Host grant edge:
  - host_ack pulses; rom_address<=host_addr; state HOST; rom_clken=1.
  - host_rdata is captured and host_rvalid pulses 2 edges after grant.
  - The state then returns to IDLE. A host read takes 3 cycles.
- A request that arrives while busy stays pending, since it is level-held. row_idx and host_addr changes after their grant are ignored.
- px_col wraps only via burst end; the address never crosses a row boundary. The row base is row_idx concatenated with 4'b0.
- host_rdata holds its last value until the next host read.

Test Plan:
- Reset, then row_req with row_idx=3, px_ready=1 -> row_ack in cycle 1. ROM words 48..63 appear on px_data with px_col 0..15 on 16 consecutive cycles starting 2 cycles after grant. row_done occurs only with px_col=15.
- Burst on row 0 with px_ready=0 for 5 cycles while px_col=7 -> px_data and px_col hold at word 7 and rom_clken=0 for the stall. Words 8..15 then follow in order, with no loss or duplication.
- host_req addr=0xA5 in IDLE -> host_ack one cycle, host_rvalid exactly 2 cycles later, host_rdata=ROM[0xA5].
- row_req and host_req asserted together from IDLE, row_req kept high -> renderer burst first with host_owed set. Host is granted immediately after the burst ends, before the second burst.
- Assert reset when px_col=9 -> all outputs 0 asynchronously, no row_done. A fresh row_idx=15 burst after release returns words 240..255.
- Back-to-back host reads of 0x00 then 0xFF -> each takes 3 cycles; both returned values are correct and host_rvalid is never asserted for 2 consecutive cycles.
